// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : mips_pkg
//  Description : Shared definitions for the HI/LO multiply/divide unit:
//                datapath width, iteration count, operation encodings,
//                controller state type and an operand magnitude helper.
//  Revision    : 1.0  initial release
// ============================================================================
package mips_pkg;

    // Datapath width and number of radix-2 iterations per operation
    localparam int c_DATA_W = 32;
    localparam int c_ITER_N = 32;
    localparam int c_CNT_W  = $clog2(c_ITER_N);

    // Operation encodings carried on i_Op (110/111 are reserved)
    typedef enum logic [2:0] {
        OP_MULT  = 3'b000,
        OP_MULTU = 3'b001,
        OP_DIV   = 3'b010,
        OP_DIVU  = 3'b011,
        OP_MTHI  = 3'b100,
        OP_MTLO  = 3'b101
    } op_e;

    // Controller states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2
    } state_e;

    // Magnitude of an operand for signed operations; raw value otherwise.
    // 32'h80000000 maps to itself, which is the correct unsigned magnitude.
    function automatic logic [c_DATA_W-1:0] abs_opnd(
        input logic [c_DATA_W-1:0] x,
        input logic                is_signed
    );
        return (is_signed && x[c_DATA_W-1]) ? (-x) : x;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mult_div_unit_if.sv
`default_nettype none
// ============================================================================
//  Interface   : mult_div_unit_if
//  Description : Request/result bundle between the issuing pipeline and the
//                multiply/divide unit.
//  Revision    : 1.0  initial release
//
//  Signals
//    i_Start  1   launch request, sampled on the rising clock edge
//    i_Op     3   operation code (see mips_pkg::op_e)
//    i_Rs     32  first operand / dividend / MTHI-MTLO source
//    i_Rt     32  second operand / divisor
//    o_Busy   1   iterative operation in progress
//    o_Done   1   one-cycle completion pulse for MULT/MULTU/DIV/DIVU
//    o_Hi     32  HI register
//    o_Lo     32  LO register
//
//  Modports
//    master : requester side (drives i_*, observes o_*)
//    slave  : unit side (observes i_*, drives o_*)
// ============================================================================
interface mult_div_unit_if;
    import mips_pkg::*;

    logic                i_Start;
    logic [2:0]          i_Op;
    logic [c_DATA_W-1:0] i_Rs;
    logic [c_DATA_W-1:0] i_Rt;
    logic                o_Busy;
    logic                o_Done;
    logic [c_DATA_W-1:0] o_Hi;
    logic [c_DATA_W-1:0] o_Lo;

    modport master (
        output i_Start, i_Op, i_Rs, i_Rt,
        input  o_Busy, o_Done, o_Hi, o_Lo
    );

    modport slave (
        input  i_Start, i_Op, i_Rs, i_Rt,
        output o_Busy, o_Done, o_Hi, o_Lo
    );

endinterface
`default_nettype wire

// File: rtl/mult_div_step.sv
`default_nettype none
// ============================================================================
//  Module      : mult_div_step
//  Description : One combinational radix-2 iteration on the {hi, lo} working
//                pair. Multiply: conditional add of the multiplicand into hi,
//                then shift the pair right. Divide: shift the pair left, trial
//                subtract the divisor, keep the difference when it does not
//                underflow and shift the quotient bit into lo.
//  Revision    : 1.0  initial release
//  Build macro : MULT_DIV_UNIT_DIV_EN -- includes the restoring-divide path;
//                when undefined only the shift-add path exists.
//
//  Ports
//    i_Is_Div  1   selects divide step (ignored without the divide build)
//    i_Hi      32  working high half (partial product / partial remainder)
//    i_Lo      32  working low half (multiplier bits / dividend+quotient bits)
//    i_Opnd    32  multiplicand or divisor magnitude
//    o_Hi      32  next working high half
//    o_Lo      32  next working low half
// ============================================================================
module mult_div_step
    import mips_pkg::*;
(
    input  wire logic                i_Is_Div,
    input  wire logic [c_DATA_W-1:0] i_Hi,
    input  wire logic [c_DATA_W-1:0] i_Lo,
    input  wire logic [c_DATA_W-1:0] i_Opnd,
    output logic      [c_DATA_W-1:0] o_Hi,
    output logic      [c_DATA_W-1:0] o_Lo
);

    // Shift-add: 33-bit sum keeps the carry that shifts into hi's MSB
    logic [c_DATA_W:0] w_add_sum;
    assign w_add_sum = {1'b0, i_Hi} + (i_Lo[0] ? {1'b0, i_Opnd} : {(c_DATA_W+1){1'b0}});

`ifdef MULT_DIV_UNIT_DIV_EN
    // Restoring divide: the shifted partial remainder can reach 33 bits, so
    // the trial difference is carried in 34 bits and its MSB is the borrow.
    logic [c_DATA_W+1:0] w_trial;
    logic                w_fits;
    assign w_trial = {1'b0, i_Hi, i_Lo[c_DATA_W-1]} - {2'b00, i_Opnd};
    assign w_fits  = ~w_trial[c_DATA_W+1];

    always_comb begin
        o_Hi = w_add_sum[c_DATA_W:1];
        o_Lo = {w_add_sum[0], i_Lo[c_DATA_W-1:1]};
        if (i_Is_Div) begin
            // When the subtract underflows the shifted value is below the
            // divisor, so its top bit is zero and 32 bits suffice.
            o_Hi = w_fits ? w_trial[c_DATA_W-1:0] : {i_Hi[c_DATA_W-2:0], i_Lo[c_DATA_W-1]};
            o_Lo = {i_Lo[c_DATA_W-2:0], w_fits};
        end
    end
`else
    logic w_unused_is_div;
    assign w_unused_is_div = i_Is_Div;

    always_comb begin
        o_Hi = w_add_sum[c_DATA_W:1];
        o_Lo = {w_add_sum[0], i_Lo[c_DATA_W-1:1]};
    end
`endif

endmodule
`default_nettype wire

// File: rtl/mult_div_unit.sv
`default_nettype none
// ============================================================================
//  Module      : mult_div_unit
//  Description : MIPS-style HI/LO multiply/divide unit. MULT/MULTU (and
//                DIV/DIVU in the divide build) run 32 radix-2 iterations
//                on operand magnitudes followed by one sign-fix cycle, giving
//                a fixed latency: start at edge N, HI/LO written and busy
//                dropped at edge N+33, o_Done high for the following cycle.
//                MTHI/MTLO write HI/LO directly when idle.
//  Revision    : 1.0  initial release
//  Build macro : MULT_DIV_UNIT_DIV_EN -- enables DIV/DIVU; without it those
//                codes are treated as reserved and no divider is built.
//
//  Ports
//    i_Clk   1   clock, rising edge
//    i_Rst   1   asynchronous active-high reset
//    bus         mult_div_unit_if.slave (i_Start, i_Op, i_Rs, i_Rt,
//                o_Busy, o_Done, o_Hi, o_Lo)
// ============================================================================
module mult_div_unit
    import mips_pkg::*;
(
    input  wire logic       i_Clk,
    input  wire logic       i_Rst,
    mult_div_unit_if.slave  bus
);

    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(c_ITER_N - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_e              state_q,   state_d;
    logic [c_CNT_W-1:0]  count_q,   count_d;
    logic [c_DATA_W-1:0] acc_hi_q,  acc_hi_d;   // working pair, separate from
    logic [c_DATA_W-1:0] acc_lo_q,  acc_lo_d;   // HI/LO so those stay stable
    logic [c_DATA_W-1:0] opnd_q,    opnd_d;     // multiplicand / divisor
    logic                is_div_q,  is_div_d;
    logic                neg_q,     neg_d;      // negate product / quotient
    logic                neg_rem_q, neg_rem_d;  // negate remainder
    logic                div0_q,    div0_d;     // divisor was zero
    logic [c_DATA_W-1:0] hi_q,      hi_d;
    logic [c_DATA_W-1:0] lo_q,      lo_d;
    logic                done_q,    done_d;

    // ------------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------------
    logic w_op_mul;
    logic w_op_div;
    logic w_op_iter;
    logic w_op_signed;

    assign w_op_mul    = (bus.i_Op == OP_MULT) || (bus.i_Op == OP_MULTU);
`ifdef MULT_DIV_UNIT_DIV_EN
    assign w_op_div    = (bus.i_Op == OP_DIV)  || (bus.i_Op == OP_DIVU);
`else
    assign w_op_div    = 1'b0;
`endif
    assign w_op_iter   = w_op_mul || w_op_div;
    assign w_op_signed = (bus.i_Op == OP_MULT) || (bus.i_Op == OP_DIV);

    // ------------------------------------------------------------------
    // Single iteration datapath
    // ------------------------------------------------------------------
    logic [c_DATA_W-1:0] w_step_hi;
    logic [c_DATA_W-1:0] w_step_lo;

    mult_div_step u_step (
        .i_Is_Div (is_div_q),
        .i_Hi     (acc_hi_q),
        .i_Lo     (acc_lo_q),
        .i_Opnd   (opnd_q),
        .o_Hi     (w_step_hi),
        .o_Lo     (w_step_lo)
    );

    // ------------------------------------------------------------------
    // Sign correction of the unsigned magnitude result
    // ------------------------------------------------------------------
    logic [2*c_DATA_W-1:0] w_prod_raw;
    logic [2*c_DATA_W-1:0] w_prod;
    logic [c_DATA_W-1:0]   w_res_hi;
    logic [c_DATA_W-1:0]   w_res_lo;

    assign w_prod_raw = {acc_hi_q, acc_lo_q};
    assign w_prod     = neg_q ? (-w_prod_raw) : w_prod_raw;

`ifdef MULT_DIV_UNIT_DIV_EN
    logic [c_DATA_W-1:0] w_quo;
    logic [c_DATA_W-1:0] w_rem;

    // With a zero divisor every trial subtract succeeds, so the remainder
    // half ends up holding |dividend|; restoring the dividend's sign gives
    // back the raw dividend. Only the quotient needs forcing.
    assign w_quo    = div0_q ? {c_DATA_W{1'b1}} : (neg_q ? (-acc_lo_q) : acc_lo_q);
    assign w_rem    = neg_rem_q ? (-acc_hi_q) : acc_hi_q;
    assign w_res_hi = is_div_q ? w_rem : w_prod[2*c_DATA_W-1:c_DATA_W];
    assign w_res_lo = is_div_q ? w_quo : w_prod[c_DATA_W-1:0];
`else
    logic w_unused_div_flags;
    assign w_unused_div_flags = ^{is_div_q, neg_rem_q, div0_q};
    assign w_res_hi = w_prod[2*c_DATA_W-1:c_DATA_W];
    assign w_res_lo = w_prod[c_DATA_W-1:0];
`endif

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        acc_hi_d  = acc_hi_q;
        acc_lo_d  = acc_lo_q;
        opnd_d    = opnd_q;
        is_div_d  = is_div_q;
        neg_d     = neg_q;
        neg_rem_d = neg_rem_q;
        div0_d    = div0_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.i_Start) begin
                    if (w_op_iter) begin
                        state_d   = ST_RUN;
                        count_d   = '0;
                        acc_hi_d  = '0;
                        acc_lo_d  = abs_opnd(bus.i_Rs, w_op_signed);
                        opnd_d    = abs_opnd(bus.i_Rt, w_op_signed);
                        is_div_d  = w_op_div;
                        neg_d     = w_op_signed && (bus.i_Rs[c_DATA_W-1] ^ bus.i_Rt[c_DATA_W-1]);
                        neg_rem_d = w_op_signed && bus.i_Rs[c_DATA_W-1];
                        div0_d    = (bus.i_Rt == '0);
                    end else if (bus.i_Op == OP_MTHI) begin
                        hi_d = bus.i_Rs;
                    end else if (bus.i_Op == OP_MTLO) begin
                        lo_d = bus.i_Rs;
                    end
                end
            end

            ST_RUN: begin
                acc_hi_d = w_step_hi;
                acc_lo_d = w_step_lo;
                count_d  = count_q + c_CNT_ONE;
                if (count_q == c_CNT_LAST) begin
                    state_d = ST_FIX;
                end
            end

            ST_FIX: begin
                hi_d    = w_res_hi;
                lo_d    = w_res_lo;
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            state_q   <= ST_IDLE;
            count_q   <= '0;
            acc_hi_q  <= '0;
            acc_lo_q  <= '0;
            opnd_q    <= '0;
            is_div_q  <= 1'b0;
            neg_q     <= 1'b0;
            neg_rem_q <= 1'b0;
            div0_q    <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            acc_hi_q  <= acc_hi_d;
            acc_lo_q  <= acc_lo_d;
            opnd_q    <= opnd_d;
            is_div_q  <= is_div_d;
            neg_q     <= neg_d;
            neg_rem_q <= neg_rem_d;
            div0_q    <= div0_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            done_q    <= done_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.o_Busy = (state_q != ST_IDLE);
    assign bus.o_Done = done_q;
    assign bus.o_Hi   = hi_q;
    assign bus.o_Lo   = lo_q;

endmodule
`default_nettype wire
